// File: rtl/c3_heap_pkg.sv
// Shared types and defaults for the C3 heap issuer front end.
package c3_heap_pkg;

  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;

  localparam int DEF_PIPE_CYCLES = 5;
  localparam int DEF_HEAP_SIZE   = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/c3_rsp_fifo.sv
// First-word-fall-through response FIFO; head entry is read straight from storage.
module c3_rsp_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // A write into a full FIFO is only legal alongside a read of the head.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd) count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/c3_heap_issuer.sv
// Core-side issuer for the C3 heap unit: one operation in flight, occupancy
// tracking, pop timeout and a response FIFO back to the core.
module c3_heap_issuer
  import c3_heap_pkg::*;
#(
  parameter int PIPE_CYCLES = DEF_PIPE_CYCLES,
  parameter int HEAP_SIZE   = DEF_HEAP_SIZE,
  parameter int RSP_DEPTH   = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_data,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        c3_in_v,
  output logic [4:0]  c3_rd,
  output logic [2:0]  c3_vrd1,
  output logic [2:0]  c3_vrd2,
  output logic [31:0] c3_in_data,
  input  logic        c3_out_v,
  input  logic [4:0]  c3_out_rd,
  input  logic [31:0] c3_out_data,
  output logic [8:0]  occupancy,
  output logic        stray_seen
);

  localparam logic [8:0] HEAP_MAX = 9'(HEAP_SIZE);
  localparam int GW = $clog2(PIPE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Handshakes: a transfer happens at a rising edge where valid & ready are
  // both 1; valid never waits on ready, and payload is held while valid.

  state_t        state;
  state_t        state_nx;
  logic [1:0]    op_q;
  logic [31:0]   data_q;
  logic [4:0]    rd_q;
  logic [8:0]    occ_q;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] timer;
  logic          stray_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          legal;
  logic          wr_en;
  rsp_t          wr_entry;
  rsp_t          head;
  logic          tag_match;

  assign req_ready = (state == IDLE) & ~fifo_full;
  assign accept    = req_valid & req_ready;
  assign legal     = ((req_op == OP_PUSH) && (occ_q < HEAP_MAX)) ||
                     ((req_op == OP_POP)  && (occ_q != 9'd0));
  assign tag_match = (c3_out_rd == rd_q);

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    wr_entry = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_nx = ISSUE;
          end else begin
            wr_en    = 1'b1;
            wr_entry = '{data: 32'd0, rd: req_rd, err: 1'b1};
          end
        end
      end
      ISSUE: state_nx = (op_q == OP_PUSH) ? GAP : WAIT;
      GAP: begin
        if (gap_cnt == GW'(PIPE_CYCLES - 1)) state_nx = IDLE;
      end
      WAIT: begin
        // A result in the final timer cycle beats the timeout.
        if (c3_out_v) begin
          wr_en    = 1'b1;
          wr_entry = '{data: c3_out_data, rd: rd_q, err: ~tag_match};
          state_nx = IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          wr_en    = 1'b1;
          wr_entry = '{data: 32'd0, rd: rd_q, err: 1'b1};
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      gap_cnt <= '0;
      timer   <= '0;
      stray_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && accept && legal) begin
        op_q   <= req_op;
        data_q <= req_data;
        rd_q   <= req_rd;
      end
      if (state == ISSUE && op_q == OP_PUSH) occ_q <= occ_q + 9'd1;
      else if (state == WAIT && c3_out_v && tag_match) occ_q <= occ_q - 9'd1;
      if (state == ISSUE) gap_cnt <= '0;
      else if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      if (state == ISSUE) timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
      if (c3_out_v && state != WAIT) stray_q <= 1'b1;
    end
  end

  assign c3_in_v    = (state == ISSUE);
  assign c3_rd      = (state == ISSUE) ? rd_q : 5'd0;
  assign c3_vrd1    = (state == ISSUE) ? {1'b0, op_q} : 3'd0;
  assign c3_vrd2    = 3'd0;
  assign c3_in_data = (state == ISSUE) ? data_q : 32'd0;
  assign occupancy  = occ_q;
  assign stray_seen = stray_q;

  c3_rsp_fifo #(
    .W     ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rsp_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_rd    = head.rd;
  assign rsp_err   = head.err;

endmodule

// File: tb/tb_c3_heap_issuer.sv
// Bench for c3_heap_issuer: the bench plays the C3 unit and tracks expected
// occupancy and responses from the command rules.
module tb_c3_heap_issuer;

  localparam int PIPE = 5;
  localparam int TMO  = 16;
  localparam int HS   = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [31:0] req_data = '0;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        c3_in_v;
  logic [4:0]  c3_rd;
  logic [2:0]  c3_vrd1;
  logic [2:0]  c3_vrd2;
  logic [31:0] c3_in_data;
  logic        c3_out_v = 1'b0;
  logic [4:0]  c3_out_rd = '0;
  logic [31:0] c3_out_data = '0;
  logic [8:0]  occupancy;
  logic        stray_seen;

  int n_checks = 0;
  int n_err    = 0;
  int m_occ    = 0;

  c3_heap_issuer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .c3_in_v(c3_in_v), .c3_rd(c3_rd), .c3_vrd1(c3_vrd1), .c3_vrd2(c3_vrd2),
    .c3_in_data(c3_in_data),
    .c3_out_v(c3_out_v), .c3_out_rd(c3_out_rd), .c3_out_data(c3_out_data),
    .occupancy(occupancy), .stray_seen(stray_seen)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    repeat (60000) @(posedge clk);
    n_err++;
    $display("FAIL watchdog: got no end of test, required finish within 60000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // beh: 0 = C3 silent, 1 = result with matching tag, 2 = result with tag ctag
  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  rd;
    int          beh;
    int          dly;
    logic [31:0] cdata;
    logic [4:0]  ctag;
    bit          e_issue;
    bit          e_rsp;
    logic [31:0] e_data;
    logic        e_err;
    int          e_occ;
  } vec_t;

  task automatic run_cmd(input vec_t v, input string name);
    int guard;
    bit bad;
    guard = 0;
    while (!req_ready && guard < 50) begin step(); guard++; end
    chk({name, "_ready_wait"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = v.op; req_data = v.data; req_rd = v.rd;
    step();
    req_valid = 1'b0;
    chk({name, "_issue"}, {63'd0, c3_in_v}, {63'd0, v.e_issue});
    if (!v.e_issue) begin
      chk({name, "_rej_rsp"}, {rsp_valid, rsp_data, rsp_rd, rsp_err},
          {1'b1, 32'd0, v.rd, 1'b1});
      chk({name, "_rej_c3"}, {c3_vrd1, c3_rd, c3_in_data}, 64'd0);
      step();
      chk({name, "_occ"}, 64'(occupancy), 64'(v.e_occ));
      return;
    end
    chk({name, "_c3_fields"}, {c3_vrd1, c3_vrd2, c3_rd, c3_in_data},
        {1'b0, v.op, 3'd0, v.rd, v.data});
    if (v.op == 2'd1) begin
      bad = 1'b0;
      for (int i = 0; i < PIPE; i++) begin
        step();
        if (req_ready || rsp_valid || c3_in_v) bad = 1'b1;
      end
      chk({name, "_gap_quiet"}, {63'd0, bad}, 64'd0);
      step();
      chk({name, "_gap_end_ready"}, {63'd0, req_ready}, 64'd1);
      chk({name, "_occ"}, 64'(occupancy), 64'(v.e_occ));
      return;
    end
    if (v.beh == 0) begin
      for (int i = 0; i < TMO; i++) step();
      chk({name, "_no_early_rsp"}, {63'd0, rsp_valid}, 64'd0);
      step();
    end else begin
      step();
      chk({name, "_strobe_one_cycle"}, {63'd0, c3_in_v}, 64'd0);
      for (int i = 1; i < v.dly; i++) step();
      c3_out_v = 1'b1; c3_out_data = v.cdata;
      c3_out_rd = (v.beh == 1) ? v.rd : v.ctag;
      step();
      c3_out_v = 1'b0;
    end
    chk({name, "_rsp"}, {rsp_valid, rsp_data, rsp_rd, rsp_err},
        {1'b1, v.e_data, v.rd, v.e_err});
    chk({name, "_occ"}, 64'(occupancy), 64'(v.e_occ));
    step();
  endtask

  // Reference: outcome of one command from the occupancy and C3 behaviour.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit legal;
    r = v;
    legal = (v.op == 2'd1 && m_occ < HS) || (v.op == 2'd2 && m_occ > 0);
    r.e_issue = legal;
    r.e_rsp = 1'b1; r.e_data = 0; r.e_err = 1'b1;
    if (legal && v.op == 2'd1) begin
      m_occ++;
      r.e_rsp = 1'b0; r.e_err = 1'b0;
    end else if (legal && v.beh == 1) begin
      m_occ--;
      r.e_data = v.cdata; r.e_err = 1'b0;
    end else if (legal && v.beh == 2) begin
      r.e_data = v.cdata;
    end
    r.e_occ = m_occ;
    return r;
  endfunction

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = '{2'd2, 32'h0,  5'd3,  0, 0,  32'h0,    5'd0, 1'b0, 1'b1, 32'h0,    1'b1, 0};
    tbl[1] = '{2'd1, 32'h10, 5'd1,  0, 0,  32'h0,    5'd0, 1'b1, 1'b0, 32'h0,    1'b0, 1};
    tbl[2] = '{2'd1, 32'h20, 5'd2,  0, 0,  32'h0,    5'd0, 1'b1, 1'b0, 32'h0,    1'b0, 2};
    tbl[3] = '{2'd2, 32'h0,  5'd7,  1, 6,  32'h20,   5'd0, 1'b1, 1'b1, 32'h20,   1'b0, 1};
    tbl[4] = '{2'd2, 32'h0,  5'd4,  0, 0,  32'h0,    5'd0, 1'b1, 1'b1, 32'h0,    1'b1, 1};
    tbl[5] = '{2'd3, 32'h5,  5'd9,  0, 0,  32'h0,    5'd0, 1'b0, 1'b1, 32'h0,    1'b1, 1};
    tbl[6] = '{2'd0, 32'h6,  5'd10, 0, 0,  32'h0,    5'd0, 1'b0, 1'b1, 32'h0,    1'b1, 1};
    tbl[7] = '{2'd2, 32'h0,  5'd5,  2, 16, 32'hABCD, 5'd6, 1'b1, 1'b1, 32'hABCD, 1'b1, 1};
    tbl[8] = '{2'd2, 32'h0,  5'd11, 1, 1,  32'h55,   5'd0, 1'b1, 1'b1, 32'h55,   1'b0, 0};

    #1;
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_outputs", {rsp_valid, rsp_data, rsp_rd, rsp_err, occupancy, stray_seen},
        64'd0);
    chk("reset_c3", {c3_in_v, c3_rd, c3_vrd1, c3_vrd2, c3_in_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    chk("post_reset_ready", {63'd0, req_ready}, 64'd1);

    // directed table
    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i], $sformatf("tbl%0d", i));
      m_occ = tbl[i].e_occ;
    end
    chk("no_stray_yet", {63'd0, stray_seen}, 64'd0);

    // randomized commands against the model
    for (int n = 0; n < 60; n++) begin
      int r;
      rv = '{default: '0};
      r = $urandom_range(0, 9);
      rv.op = (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : (($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3);
      rv.data = $urandom; rv.rd = 5'($urandom_range(0, 31));
      rv.beh = $urandom_range(0, 3); if (rv.beh == 3) rv.beh = 1;
      rv.dly = $urandom_range(1, TMO); rv.cdata = $urandom;
      rv.ctag = rv.rd ^ 5'($urandom_range(1, 31));
      rv = model(rv);
      run_cmd(rv, $sformatf("rnd%0d", n));
    end
    chk("rnd_no_stray", {63'd0, stray_seen}, 64'd0);

    // response backpressure: fill the FIFO with rejections
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int guard = 0;
      while (!req_ready && guard < 20) begin step(); guard++; end
      req_valid = 1'b1; req_op = 2'd0; req_rd = 5'(20 + k);
      step();
      req_valid = 1'b0;
    end
    chk("bp_full_ready", {63'd0, req_ready}, 64'd0);
    chk("bp_head", {rsp_valid, rsp_rd, rsp_err}, {57'd0, 1'b1, 5'd20, 1'b1});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_ready_back", {63'd0, req_ready}, 64'd1);
    rsp_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("bp_order%0d", k), {rsp_valid, rsp_data, rsp_rd, rsp_err},
          {1'b1, 32'd0, 5'(20 + k), 1'b1});
      step();
    end
    chk("bp_drained", {63'd0, rsp_valid}, 64'd0);

    // stray result while idle
    c3_out_v = 1'b1; c3_out_rd = 5'd1; c3_out_data = 32'hDEAD;
    step();
    c3_out_v = 1'b0;
    chk("stray_set", {63'd0, stray_seen}, 64'd1);
    chk("stray_no_effect", {rsp_valid, occupancy}, {54'd0, 1'b0, 9'(m_occ)});

    // fill to capacity, then a push must be rejected
    while (m_occ < HS) begin
      rv = '{default: '0};
      rv.op = 2'd1; rv.data = $urandom; rv.rd = 5'($urandom_range(0, 31));
      rv = model(rv);
      run_cmd(rv, "fill");
    end
    chk("full_occ", 64'(occupancy), 64'(HS));
    rv = '{default: '0};
    rv.op = 2'd1; rv.data = 32'h77; rv.rd = 5'd17;
    rv = model(rv);
    run_cmd(rv, "push_full");
    rv = '{default: '0};
    rv.op = 2'd2; rv.rd = 5'd18; rv.beh = 1; rv.dly = 3; rv.cdata = 32'h99;
    rv = model(rv);
    run_cmd(rv, "pop_after_full");

    // reset mid-pop; the late result counts as stray
    req_valid = 1'b1; req_op = 2'd2; req_rd = 5'd1;
    step();
    req_valid = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    chk("midrst_state", {occupancy, stray_seen, rsp_valid, c3_in_v, req_ready},
        64'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    c3_out_v = 1'b1; c3_out_rd = 5'd1;
    step();
    c3_out_v = 1'b0;
    chk("midrst_stray", {rsp_valid, occupancy, stray_seen}, {53'd0, 1'b0, 9'd0, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
